// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch unit.
package rv32_fetch_pkg;
  localparam int          FETCH_XLEN  = 32;
  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;
endpackage

// File: rtl/rv32_fetch_fifo.sv
// Small power-of-2 FIFO with synchronous clear and occupancy output; head is
// the oldest entry and is only meaningful while count_o is non-zero.
module rv32_fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0],
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  T              push_dat_i,
  input  logic          pop_i,
  output T              head_o,
  output logic [CW-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/rv32_fetch_unit.sv
// Pipelined instruction fetch with DEPTH-entry prefetch queue and redirect flush.
// Define RV_FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module rv32_fetch_unit
  import rv32_fetch_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            dec_valid,
  output logic [31:0]     dec_instr,
  output logic [XLEN-1:0] dec_pc,
  input  logic            dec_ready
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   q_count, tag_count;
  logic [CW:0]     occupancy;
  logic [XLEN-1:0] tag_head;
  fetch_entry_t    q_head, q_in;
  logic            issue, live_rsp, bypass, q_push, q_pop;
  logic            unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  // Credit counts both queued entries and every outstanding request, discards included.
  assign occupancy = {1'b0, q_count} + {1'b0, inflight_q};
  assign imem_req  = rst_n && !halt && !redirect && (occupancy < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign issue     = imem_req && imem_gnt;
  assign live_rsp  = imem_rvalid && (discard_q == '0) && !redirect;

`ifdef RV_FETCH_BYPASS_EN
  assign bypass = live_rsp && (q_count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign q_push    = live_rsp && !(bypass && dec_ready);
  assign q_pop     = (q_count != '0) && dec_ready;
  assign dec_valid = (q_count != '0) || bypass;
  assign q_in      = '{pc: FETCH_XLEN'(tag_head), instr: imem_rdata};

  always_comb begin
    dec_instr = '0;
    dec_pc    = '0;
    if (q_count != '0) begin
      dec_instr = q_head.instr;
      dec_pc    = XLEN'(q_head.pc);
    end else if (bypass) begin
      dec_instr = imem_rdata;
      dec_pc    = tag_head;
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    inflight_d = inflight_q + CW'(issue) - CW'(imem_rvalid);
    if (issue) fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
    if (redirect) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      discard_d  = inflight_q - CW'(imem_rvalid);
    end else if (imem_rvalid && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  rv32_fetch_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_tag_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (redirect),
    .push_i     (issue),
    .push_dat_i (fetch_pc_q),
    .pop_i      (live_rsp),
    .head_o     (tag_head),
    .count_o    (tag_count)
  );

  rv32_fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_entry_q (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (redirect),
    .push_i     (q_push),
    .push_dat_i (q_in),
    .pop_i      (q_pop),
    .head_o     (q_head),
    .count_o    (q_count)
  );

  a_rvalid_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (inflight_q != '0));
  a_tag_tracks_live: assert property (@(posedge clk) disable iff (!rst_n)
    tag_count == (inflight_q - discard_q));
endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Randomized bench for rv32_fetch_unit against a PC-stream / credit-count reference model.
module tb_rv32_fetch_unit;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
`ifdef RV_FETCH_BYPASS_EN
  localparam int BYP_LAT = 0;
`else
  localparam int BYP_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;

  always #5 clk = ~clk;

  rv32_fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready)
  );

  typedef struct { logic [31:0] addr; int due; } rsp_t;
  rsp_t pend[$];

  int g_cmp = 0, g_bad = 0, cyc = 0;
  int g_pgnt, g_lat_lo, g_lat_hi, g_pready, g_predir, g_phalt;
  logic [31:0] m_pc, m_exp_pc;
  int m_infl, m_disc, m_q;
  logic [31:0] prev_gnt_addr;
  bit prev_gnt_vld, wrap_seen, want_first, chk_stream, f_redir;
  logic [31:0] want_pc, f_pc;
  int stream_from;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F13;
  endfunction

  function automatic logic [31:0] rand_pc();
    case ($urandom_range(3))
      0:       return 32'h0000_0100;
      1:       return 32'hFFFF_FFF8;
      default: return $urandom & 32'h0000_FFFF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    g_cmp++;
    if (obs !== expv) begin
      g_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic step();
    bit rv, acc, pop, dv_exp, req_exp, grant;
    @(posedge clk); #1;
    imem_gnt  = ($urandom_range(99) < g_pgnt);
    halt      = ($urandom_range(99) < g_phalt);
    dec_ready = ($urandom_range(99) < g_pready);
    if (f_redir) begin
      redirect = 1'b1; redirect_pc = f_pc; f_redir = 1'b0;
    end else begin
      redirect = ($urandom_range(99) < g_predir); redirect_pc = rand_pc();
    end
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1; imem_rdata = mem_fn(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    @(negedge clk);
    rv      = imem_rvalid;
    req_exp = !halt && !redirect && (m_q + m_infl < DEPTH);
    check("req_rule", 32'(imem_req), 32'(req_exp));
    if (req_exp) check("issue_addr", imem_addr, m_pc);
    acc    = rv && (m_disc == 0) && !redirect;
    dv_exp = (m_q > 0) || (BYP_LAT == 0 && acc);
    check("dec_valid", 32'(dec_valid), 32'(dv_exp));
    if (dv_exp) begin
      check("dec_pc", dec_pc, m_exp_pc);
      check("dec_instr", dec_instr, mem_fn(m_exp_pc));
    end
    if (chk_stream && cyc >= stream_from) check("no_bubble", 32'(dec_valid), 32'd1);
    if (want_first && dv_exp) begin
      check("redir_first", dec_pc, want_pc);
      want_first = 1'b0;
    end
    grant = imem_req && imem_gnt;
    if (grant) begin
      if (prev_gnt_vld && prev_gnt_addr == 32'hFFFF_FFFC) begin
        check("wrap", imem_addr, 32'h0);
        wrap_seen = 1'b1;
      end
      prev_gnt_addr = imem_addr; prev_gnt_vld = 1'b1;
      pend.push_back('{addr: imem_addr, due: cyc + $urandom_range(g_lat_hi, g_lat_lo)});
    end
    pop = dv_exp && dec_ready;
    if (redirect) begin
      m_disc = m_infl - int'(rv);
      m_infl = m_infl - int'(rv);
      m_q = 0;
      m_pc = {redirect_pc[31:2], 2'b00};
      m_exp_pc = m_pc;
      prev_gnt_vld = 1'b0;
    end else begin
      if (rv) begin
        if (m_disc > 0) m_disc--;
        m_infl--;
      end
      if (req_exp && imem_gnt) begin
        m_infl++;
        m_pc = m_pc + 32'd4;
      end
      m_q = m_q + int'(acc) - int'(pop);
      if (pop) m_exp_pc = m_exp_pc + 32'd4;
    end
    cyc++;
  endtask

  task automatic knobs(input int pg, input int lo, input int hi, input int pr, input int pd, input int ph);
    g_pgnt = pg; g_lat_lo = lo; g_lat_hi = hi; g_pready = pr; g_predir = pd; g_phalt = ph;
  endtask

  task automatic quiesce();
    int n = 0;
    knobs(100, 1, 1, 100, 0, 100);
    while ((m_infl != 0 || m_q != 0 || pend.size() != 0) && n < 60) begin
      step();
      n++;
    end
    if (n >= 60) check("quiesce_timeout", n, 0);
  endtask

  initial begin
    int rv_c, dv_c;
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; halt = 1'b0; dec_ready = 1'b0;
    m_pc = 32'h0; m_exp_pc = 32'h0; m_infl = 0; m_disc = 0; m_q = 0;
    prev_gnt_vld = 0; wrap_seen = 0; want_first = 0; chk_stream = 0; f_redir = 0;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_dec_instr", dec_instr, 32'h0);
    check("rst_dec_pc", dec_pc, 32'h0);
    rst_n = 1'b1;

    // Zero-wait memory, decode always ready: back-to-back stream after fill.
    knobs(100, 1, 1, 100, 0, 0);
    chk_stream = 1'b1; stream_from = cyc + 3;
    repeat (30) step();
    chk_stream = 1'b0;

    // Decode stall with 2-cycle memory.
    knobs(100, 2, 2, 0, 0, 0);
    repeat (10) step();
    g_pready = 100;
    repeat (10) step();

    // Redirect with three requests outstanding.
    quiesce();
    knobs(100, 3, 3, 100, 0, 0);
    repeat (3) step();
    check("inflight_before_redir", m_infl, 3);
    f_redir = 1'b1; f_pc = 32'h100;
    step();
    want_first = 1'b1; want_pc = 32'h100;
    repeat (15) step();
    check("redir_first_seen", 32'(want_first), 32'd0);

    // Unaligned redirect target.
    knobs(0, 1, 1, 100, 0, 0);
    f_redir = 1'b1; f_pc = 32'h203;
    step();
    step();
    check("redir_align", imem_addr, 32'h200);

    // Address wrap at the top of memory.
    knobs(100, 1, 1, 100, 0, 0);
    f_redir = 1'b1; f_pc = 32'hFFFF_FFFC;
    repeat (12) step();
    check("wrap_seen", 32'(wrap_seen), 32'd1);

    // Halt with two outstanding: both drain, then nothing.
    quiesce();
    knobs(100, 2, 2, 0, 0, 0);
    repeat (2) step();
    knobs(100, 2, 2, 100, 0, 100);
    repeat (8) step();
    check("halt_req", 32'(imem_req), 32'd0);
    check("halt_drain", 32'(dec_valid), 32'd0);

    // Single fetch on an empty queue: response-to-decode latency.
    quiesce();
    knobs(100, 1, 1, 100, 0, 0);
    step();
    g_phalt = 100;
    rv_c = -1; dv_c = -1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (imem_rvalid && rv_c < 0) rv_c = cyc;
      if (dec_valid && dv_c < 0) dv_c = cyc;
    end
    check("byp_lat", dv_c - rv_c, BYP_LAT);

    // Random traffic.
    knobs(70, 1, 3, 60, 4, 10);
    repeat (3000) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", g_cmp, g_bad);
    $finish;
  end
endmodule
